// File: rtl/subtrator_serial_4bits_pkg.sv
// Shared constants for the bit-serial subtractor: default width, counter sizing and FSM states.
package subtrator_serial_4bits_pkg;

    localparam int unsigned DefaultN    = 4;
    localparam int unsigned DefaultCntW = $clog2(DefaultN);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/subtrator_serial_4bits_if.sv
// Operand/result bundle of the serial subtractor; master drives operands, slave returns results.
interface subtrator_serial_4bits_if #(
    parameter int unsigned N = 4
);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bin;
    logic [N-1:0] D;
    logic         Bout;
    logic         V;
    logic         busy;
    logic         done;

    modport master (
        output start, A, B, Bin,
        input  D, Bout, V, busy, done
    );

    modport slave (
        input  start, A, B, Bin,
        output D, Bout, V, busy, done
    );
endinterface

// File: rtl/subtrator_completo.sv
// 1-bit full subtractor: d = a - b - bin, with borrow out.
module subtrator_completo (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/subtrator_serial_4bits.sv
// Bit-serial subtractor D = A - B - Bin, LSB first, one bit per clock; done pulses for one cycle.
module subtrator_serial_4bits
    import subtrator_serial_4bits_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic                      clk,
    input  logic                      rst,
    subtrator_serial_4bits_if.slave   bus
);
    localparam int unsigned CntW = cnt_width(N);

    state_e          r_state;
    state_e          w_state_next;
    logic [N-1:0]    r_sa;
    logic [N-1:0]    r_sb;
    logic [N-1:0]    r_res;
    logic [N-1:0]    r_d;
    logic            r_borrow;
    logic            r_bout;
    logic            r_v;
    logic            r_a_msb;
    logic            r_b_msb;
    logic [CntW-1:0] r_cnt;
    logic            w_diff;
    logic            w_borrow_next;
    logic            w_last;

    subtrator_completo u_bit (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .bin  (r_borrow),
        .d    (w_diff),
        .bout (w_borrow_next)
    );

    assign w_last = (r_cnt == CntW'(N - 1));

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (bus.start) w_state_next = StCalc;
            StCalc:  if (w_last) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_d      <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_v      <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_sa     <= bus.A;
                        r_sb     <= bus.B;
                        r_borrow <= bus.Bin;
                        r_a_msb  <= bus.A[N-1];
                        r_b_msb  <= bus.B[N-1];
                        r_cnt    <= '0;
                    end
                end
                StCalc: begin
                    r_sa     <= r_sa >> 1;
                    r_sb     <= r_sb >> 1;
                    r_borrow <= w_borrow_next;
                    r_res    <= {w_diff, r_res[N-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                    // Results publish on the final bit; w_diff is the new D MSB.
                    if (w_last) begin
                        r_d    <= {w_diff, r_res[N-1:1]};
                        r_bout <= w_borrow_next;
                        r_v    <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_diff);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.D    = r_d;
    assign bus.Bout = r_bout;
    assign bus.V    = r_v;
    assign bus.busy = (r_state != StIdle);
    assign bus.done = (r_state == StDone);

endmodule

// File: tb/tb_subtrator_serial_4bits.sv
// Self-checking bench: cycle model of the subtractor plus directed vectors with literal results.
module tb_subtrator_serial_4bits;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst;
    bit   chk_en = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    subtrator_serial_4bits_if #(.N(N)) bus ();

    subtrator_serial_4bits #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: cycles remaining until idle, plus published and pending results.
    int           m_left;
    logic [N-1:0] m_d, m_pd;
    logic         m_bout, m_pbout, m_v, m_pv;

    function automatic logic [N+1:0] ref_sub(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic bin);
        int           r;
        logic [N-1:0] d;
        logic         bo;
        logic         v;
        r  = int'(a) - int'(b) - int'(bin);
        d  = r[N-1:0];
        bo = (r < 0);
        v  = (a[N-1] ^ b[N-1]) & (a[N-1] ^ d[N-1]);
        return {bo, v, d};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_left <= 0;
            m_d    <= '0;
            m_bout <= 1'b0;
            m_v    <= 1'b0;
        end else if (m_left == 0) begin
            if (bus.start) begin
                m_left <= N + 1;
                {m_pbout, m_pv, m_pd} <= ref_sub(bus.A, bus.B, bus.Bin);
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                m_d    <= m_pd;
                m_bout <= m_pbout;
                m_v    <= m_pv;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(bus.busy), 32'(m_left > 0));
            check("done", 32'(bus.done), 32'(m_left == 1));
            check("D",    32'(bus.D),    32'(m_d));
            check("Bout", 32'(bus.Bout), 32'(m_bout));
            check("V",    32'(bus.V),    32'(m_v));
        end
    end

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!bus.done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                          input logic [N-1:0] ed, input logic eb, input logic ev);
        int cyc;
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = bin;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
        bus.Bin   = ~bin;
        wait_done(cyc);
        check("latency", 32'(cyc), 32'd4);
        check("lit_D",    32'(bus.D),    32'(ed));
        check("lit_Bout", 32'(bus.Bout), 32'(eb));
        check("lit_V",    32'(bus.V),    32'(ev));
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Bin   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_D",    32'(bus.D),    32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(4'b0010, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0);
        run_op(4'b0010, 4'b0110, 1'b0, 4'b1100, 1'b1, 1'b0);
        run_op(4'b0010, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0);
        run_op(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        run_op(4'b1010, 4'b1110, 1'b1, 4'b1011, 1'b1, 1'b0);
        run_op(4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1);
        run_op(4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1);
        run_op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0);
        run_op(4'b1000, 4'b0111, 1'b1, 4'b0000, 1'b0, 1'b1);

        // A second start while busy must be ignored.
        bus.start = 1'b1;
        bus.A     = 4'b0011;
        bus.B     = 4'b0001;
        bus.Bin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 4'b1111;
        bus.B     = 4'b0000;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(cyc);
        check("ign_latency", 32'(cyc), 32'd2);
        check("ign_D", 32'(bus.D), 32'b0010);
        @(negedge clk);

        // Reset mid-calculation abandons the operation and clears the results.
        bus.start = 1'b1;
        bus.A     = 4'b0110;
        bus.B     = 4'b0001;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rr_D",    32'(bus.D),    32'd0);
        check("rr_Bout", 32'(bus.Bout), 32'd0);
        check("rr_V",    32'(bus.V),    32'd0);
        check("rr_busy", 32'(bus.busy), 32'd0);
        check("rr_done", 32'(bus.done), 32'd0);
        repeat (6) @(negedge clk);
        run_op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/subtrator_serial_4bits.md
Name: subtrator_serial_4bits

Overview:
Bit-serial subtractor that computes D = A - B - Bin, one bit per clock, LSB first. It is the inverse arithmetic path to the parallel 4-bit adder with carry-in/carry-out, and reuses the same A/B/carry-style interface with borrow in place of carry. Operands are captured on a start handshake, and the result is presented with a one-cycle done pulse. It sits in the same arithmetic datapath as the adder blocks, for area-constrained subtraction.

Parameters:
N, 4, operand and result width in bits (N >= 2).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request to begin a subtraction; sampled only in IDLE.
A  input  N  minuend; captured on accepted start.
B  input  N  subtrahend; captured on accepted start.
Bin  input  1  borrow in; captured on accepted start.
D  output  N  difference A - B - Bin mod 2^N.
Bout  output  1  borrow out; 1 when A < B + Bin (unsigned).
V  output  1  signed (two's-complement) overflow of the subtraction.
busy  output  1  high in CALC and DONE states.
done  output  1  one-cycle pulse; D/Bout/V are valid while it is high.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE; D=0, Bout=0, V=0, busy=0, done=0; internal shift registers, borrow flop and bit counter cleared.
- Reset has priority over every other event, including mid-CALC: the operation is abandoned and no done pulse is issued.
- States are IDLE, CALC and DONE.
- IDLE:
  - When start=1 at an edge, load A into shift register sa, B into sb, and Bin into the borrow flop. Clear the counter to 0 and go to CALC.
  - D/Bout/V keep their previous results.
- CALC, each edge:
  - a=sa[0], b=sb[0], w=borrow.
  - Difference bit = a^b^w.
  - Borrow next = (~a&b) | (~(a^b)&w).
  - Shift sa and sb right. Shift the difference bit into the result register at the MSB, moving the other bits right.
  - Increment the counter.
- End of CALC: at the edge where the counter equals N-1, the final bit is processed and the state goes to DONE. On that same edge:
  - D is updated from the completed result register.
  - Bout takes the final borrow.
  - V = (A[N-1]^B[N-1]) & (A[N-1]^D[N-1]), using the captured operand MSBs.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
- Latency: start accepted at edge k gives done=1 in the cycle following edge k+N (N+1 cycles start-to-done for N=4: 5 cycles).
- Throughput: one operation per N+2 cycles.
- start while busy=1 (CALC or DONE) is ignored and does not queue.
- Operand changes after the accepting edge have no effect.
- D/Bout/V hold stable from done until the end of the next completed operation. They are not cleared on a new start.
- Wrap-around is modulo 2^N. Bout reports unsigned underflow; V reports signed overflow. Both are independent of each other.

Decomposition:
- Shared package: state encoding constants (IDLE, CALC, DONE), default width constant N=4, and counter width $clog2(N).
- One natural sub-module: subtrator_completo, a 1-bit full subtractor.
  - Inputs a, b, bin; outputs d, bout.
  - Combinational.
  - Instantiated once for the serial bit slice.

Test Plan:
- A=0010, B=0001, Bin=0, start pulse -> after 5 cycles done=1, D=0001, Bout=0, V=0.
- A=0010, B=0110, Bin=0 -> D=1100, Bout=1, V=0. Follow with A=0010, B=0001, Bin=1 -> D=0000, Bout=0.
- A=0000, B=0000, Bin=0 -> D=0000, Bout=0, V=0. Then A=1010, B=1110, Bin=1 -> D=1011, Bout=1, V=0.
- A=0111, B=1000, Bin=0 (7 - (-8)) -> D=1111, Bout=1, V=1. A=1000, B=0001, Bin=0 -> D=0111, Bout=0, V=1.
- Start A=0011, B=0001; re-assert start with A=1111, B=0000 two cycles later -> second start ignored. Done after 5 cycles with D=0010; busy high for cycles 1-5.
- Start an operation and assert rst=1 for one cycle at cycle 2 -> no done pulse; D=0000, Bout=0, V=0, busy=0. A subsequent start (A=0101, B=0011) -> D=0010 after 5 cycles.
